// File: rtl/btn_debouncer_if.sv
// btn_debouncer_if: raw button levels in, press strobes and debounced levels out
interface btn_debouncer_if #(parameter int N_BTN = 3);
  logic [N_BTN-1:0] i_btn;
  logic [N_BTN-1:0] o_pulse;
  logic [N_BTN-1:0] o_level;
  modport master (output i_btn, input o_pulse, o_level);
  modport slave (input i_btn, output o_pulse, o_level);
endinterface

// File: rtl/btn_debouncer.sv
// btn_debouncer: per-button 2-flop synchroniser, debounce FSM and single-cycle press strobe
module btn_debouncer #(
  parameter int N_BTN = 3,
  parameter int DB_CYCLES = 16,
  parameter int NB_CNT = 20
) (
  input logic i_clk,
  input logic i_reset,
  btn_debouncer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  localparam logic [NB_CNT-1:0] LAST = NB_CNT'(DB_CYCLES - 1);
  localparam bit ONE = DB_CYCLES == 1;
  genvar i;
  for (i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0] syncQ;
    logic [NB_CNT-1:0] cnt;
    state_t state;
    logic pulseQ, levelQ, s;
    assign s = syncQ[1];
    assign bus.o_pulse[i] = pulseQ;
    assign bus.o_level[i] = levelQ;
    // cnt holds the number of consecutive samples seen at the candidate level
    always_ff @(posedge i_clk or negedge i_reset)
      if (!i_reset) begin
        syncQ <= '0;
        cnt <= '0;
        state <= IDLE;
        pulseQ <= 1'b0;
        levelQ <= 1'b0;
      end else begin
        syncQ <= {syncQ[0], bus.i_btn[i]};
        pulseQ <= 1'b0;
        case (state)
          IDLE:
            if (s) begin
              state <= ONE ? PRESSED : PRESS_WAIT;
              cnt <= ONE ? '0 : NB_CNT'(1);
              pulseQ <= ONE;
              levelQ <= ONE;
            end
          PRESS_WAIT:
            if (!s) begin
              state <= IDLE;
              cnt <= '0;
            end else if (cnt == LAST) begin
              state <= PRESSED;
              cnt <= '0;
              pulseQ <= 1'b1;
              levelQ <= 1'b1;
            end else cnt <= cnt + 1'b1;
          PRESSED:
            if (!s) begin
              state <= ONE ? IDLE : RELEASE_WAIT;
              cnt <= ONE ? '0 : NB_CNT'(1);
              levelQ <= !ONE;
            end
          RELEASE_WAIT:
            if (s) begin
              state <= PRESSED;
              cnt <= '0;
            end else if (cnt == LAST) begin
              state <= IDLE;
              cnt <= '0;
              levelQ <= 1'b0;
            end else cnt <= cnt + 1'b1;
        endcase
      end
  end
endmodule

// File: tb/tb_btn_debouncer.sv
// tb_btn_debouncer: vector table, latency sequences and randomized run against a sample-history model
module tb_btn_debouncer;
  localparam int DB = 16;
  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [2:0] expPulse = '0;
  logic [2:0] expLevel = '0;
  logic [2:0] hist[$];
  typedef struct {
    logic [2:0] btn;
    int cycles;
    int pulses;
    logic [2:0] level;
  } vec_t;
  vec_t tbl[7];

  btn_debouncer_if #(.N_BTN(3)) bus();
  btn_debouncer #(.N_BTN(3), .DB_CYCLES(DB), .NB_CNT(20)) dut (.i_clk(i_clk), .i_reset(i_reset), .bus(bus));

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Level flips once the last DB synchronised samples all disagree with it
  task automatic modelEdge(input logic [2:0] b);
    logic [2:0] nl;
    hist.push_back(b);
    if (hist.size() > DB + 2) void'(hist.pop_front());
    nl = expLevel;
    for (int c = 0; c < 3; c++) begin
      bit all;
      all = 1'b1;
      for (int j = 0; j < DB; j++) begin
        int idx;
        logic v;
        idx = hist.size() - 3 - j;
        v = idx >= 0 ? hist[idx][c] : 1'b0;
        if (v == expLevel[c]) all = 1'b0;
      end
      if (all) nl[c] = ~expLevel[c];
    end
    expPulse = nl & ~expLevel;
    expLevel = nl;
  endtask

  task automatic modelReset();
    hist.delete();
    expPulse = '0;
    expLevel = '0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (i_reset) modelEdge(bus.i_btn);
    @(negedge i_clk);
    check("pulse", int'(bus.o_pulse), int'(expPulse));
    check("level", int'(bus.o_level), int'(expLevel));
  endtask

  task automatic edgesToPulse(input int ch, output int k);
    k = -1;
    for (int n = 1; n <= 40 && k < 0; n++) begin
      tick();
      if (bus.o_pulse[ch]) k = n;
    end
  endtask

  task automatic edgesToFall(input int ch, output int k);
    k = -1;
    for (int n = 1; n <= 40 && k < 0; n++) begin
      tick();
      if (!bus.o_level[ch]) k = n;
    end
  endtask

  task automatic assertReset();
    #2 i_reset = 1'b0;
    #1;
    modelReset();
    check("reset_pulse", int'(bus.o_pulse), 0);
    check("reset_level", int'(bus.o_level), 0);
  endtask

  initial begin
    int k, cnt;
    tbl[0] = '{3'b000, 4, 0, 3'b000};
    tbl[1] = '{3'b001, 60, 1, 3'b001};
    tbl[2] = '{3'b000, 30, 0, 3'b000};
    tbl[3] = '{3'b100, 10, 0, 3'b000};
    tbl[4] = '{3'b000, 30, 0, 3'b000};
    tbl[5] = '{3'b111, 30, 3, 3'b111};
    tbl[6] = '{3'b000, 30, 0, 3'b000};
    bus.i_btn = 3'b101;
    #1;
    check("por_pulse", int'(bus.o_pulse), 0);
    check("por_level", int'(bus.o_level), 0);
    repeat (3) tick();
    bus.i_btn = '0;
    #2 i_reset = 1'b1;
    for (int t = 0; t < 7; t++) begin
      bus.i_btn = tbl[t].btn;
      cnt = 0;
      for (int c = 0; c < tbl[t].cycles; c++) begin
        tick();
        cnt += $countones(bus.o_pulse);
      end
      check($sformatf("vec%0d_pulses", t), cnt, tbl[t].pulses);
      check($sformatf("vec%0d_level", t), int'(bus.o_level), int'(tbl[t].level));
    end
    // clean press: exact press and release latency
    bus.i_btn = 3'b001;
    edgesToPulse(0, k);
    check("press_latency", k, DB + 2);
    cnt = 0;
    repeat (40) begin
      tick();
      cnt += $countones(bus.o_pulse);
      check("hold_level", int'(bus.o_level[0]), 1);
    end
    check("hold_no_pulse", cnt, 0);
    bus.i_btn = 3'b000;
    edgesToFall(0, k);
    check("release_latency", k, DB + 2);
    repeat (5) tick();
    // press bounce on channel 1
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      bus.i_btn = ((c / 3) % 2 == 0) ? 3'b010 : 3'b000;
      tick();
      cnt += $countones(bus.o_pulse);
    end
    check("bounce_no_pulse", cnt, 0);
    bus.i_btn = 3'b010;
    edgesToPulse(1, k);
    check("bounce_latency", k, DB + 2);
    repeat (10) tick();
    bus.i_btn = 3'b000;
    repeat (30) tick();
    // release bounce on channel 0
    bus.i_btn = 3'b001;
    repeat (25) tick();
    cnt = 0;
    for (int c = 0; c < 35; c++) begin
      bus.i_btn = (c < 5) ? 3'b000 : 3'b001;
      tick();
      cnt += $countones(bus.o_pulse);
      check("rel_bounce_level", int'(bus.o_level[0]), 1);
    end
    check("rel_bounce_no_pulse", cnt, 0);
    bus.i_btn = 3'b000;
    repeat (30) tick();
    // asynchronous reset 10 samples into the press wait
    bus.i_btn = 3'b001;
    repeat (12) tick();
    assertReset();
    cnt = 0;
    repeat (3) begin
      tick();
      cnt += $countones(bus.o_pulse);
    end
    check("in_reset_no_pulse", cnt, 0);
    #2 i_reset = 1'b1;
    edgesToPulse(0, k);
    check("post_reset_latency", k, DB + 2);
    bus.i_btn = 3'b000;
    repeat (30) tick();
    // randomized run with alternating bounce-heavy and calm windows
    for (int w = 0; w < 20; w++) begin
      int pr;
      pr = (w % 2 == 0) ? 4 : 40;
      for (int c = 0; c < 150; c++) begin
        logic [2:0] b;
        b = bus.i_btn;
        for (int ch = 0; ch < 3; ch++)
          if ($urandom_range(0, pr - 1) == 0) b[ch] = ~b[ch];
        bus.i_btn = b;
        if ($urandom_range(0, 399) == 0) begin
          assertReset();
          tick();
          #2 i_reset = 1'b1;
        end
        tick();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
